// File: rtl/vga_sync_generator_if.sv
// Video timing bundle between the sync generator and its consumer:
// pixel-tick enable in, sync/blanking/position outputs back.
interface vga_sync_generator_if #(
   parameter int HW = 10,
   parameter int VW = 10
);
   logic          pix_en;
   logic          hsync;
   logic          vsync;
   logic          video_on;
   logic [HW-1:0] x;
   logic [VW-1:0] y;
   logic          line_start;
   logic          frame_start;

   modport master (
      output pix_en,
      input  hsync, vsync, video_on, x, y, line_start, frame_start
   );

   modport slave (
      input  pix_en,
      output hsync, vsync, video_on, x, y, line_start, frame_start
   );
endinterface

// File: rtl/vga_sync_generator.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking and line/frame start strobes, all aligned to the x/y outputs.
module vga_sync_generator #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0
) (
   input logic clock,
   input logic res,
   vga_sync_generator_if.slave bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ZERO      = {HW{1'b0}};
   localparam logic [HW-1:0] H_ONE       = HW'(1);
   localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS       = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_LO   = HW'(H_ACTIVE + H_FRONT);
   localparam logic [HW-1:0] H_SYNC_HI   = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [VW-1:0] V_ZERO      = {VW{1'b0}};
   localparam logic [VW-1:0] V_ONE       = VW'(1);
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS       = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_LO   = VW'(V_ACTIVE + V_FRONT);
   localparam logic [VW-1:0] V_SYNC_HI   = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
   localparam logic          HS_ON       = (H_POL != 0) ? 1'b1 : 1'b0;
   localparam logic          VS_ON       = (V_POL != 0) ? 1'b1 : 1'b0;

   logic [HW-1:0] h_r, h_next_s;
   logic [VW-1:0] v_r, v_next_s;
   logic          h_wrap_s, v_wrap_s;
   logic          hsync_r, vsync_r, video_on_r, line_start_r, frame_start_r;
   logic          hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s;

   // Next counter values for an enabled or idle pixel slot.
   always_comb begin
      h_wrap_s = (h_r == H_LAST);
      v_wrap_s = (v_r == V_LAST);
      h_next_s = h_r;
      v_next_s = v_r;
      if (bus.pix_en) begin
         if (h_wrap_s) begin
            h_next_s = H_ZERO;
            v_next_s = v_wrap_s ? V_ZERO : (v_r + V_ONE);
         end else begin
            h_next_s = h_r + H_ONE;
            v_next_s = v_r;
         end
      end else begin
         h_next_s = h_r;
         v_next_s = v_r;
      end
   end

   // Outputs decoded from the next counts so they land with zero skew to x/y.
   always_comb begin
      hsync_s       = ((h_next_s >= H_SYNC_LO) && (h_next_s <= H_SYNC_HI)) ? HS_ON : ~HS_ON;
      vsync_s       = ((v_next_s >= V_SYNC_LO) && (v_next_s <= V_SYNC_HI)) ? VS_ON : ~VS_ON;
      video_on_s    = (h_next_s < H_VIS) && (v_next_s < V_VIS);
      line_start_s  = bus.pix_en && h_wrap_s;
      frame_start_s = bus.pix_en && h_wrap_s && v_wrap_s;
   end

   // Counter and output registers; reset parks on the last pixel of the frame
   // so the first enabled tick lands on (0,0) with a frame strobe.
   always_ff @(posedge clock) begin
      if (!res) begin
         h_r           <= H_LAST;
         v_r           <= V_LAST;
         hsync_r       <= ~HS_ON;
         vsync_r       <= ~VS_ON;
         video_on_r    <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         h_r           <= h_next_s;
         v_r           <= v_next_s;
         hsync_r       <= hsync_s;
         vsync_r       <= vsync_s;
         video_on_r    <= video_on_s;
         line_start_r  <= line_start_s;
         frame_start_r <= frame_start_s;
      end
   end

   assign bus.x           = h_r;
   assign bus.y           = v_r;
   assign bus.hsync       = hsync_r;
   assign bus.vsync       = vsync_r;
   assign bus.video_on    = video_on_r;
   assign bus.line_start  = line_start_r;
   assign bus.frame_start = frame_start_r;
endmodule

// File: doc/vga_sync_generator.md
VGA_SYNC_GENERATOR -- requirements
Module: vga_sync_generator

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: `clock` is the single clock, `res` is the reset, and both are sampled on the rising edge of `clock`.
REQ-002 Parameter H_ACTIVE, default 640, SHALL set the visible pixels per line.
REQ-003 Parameter H_FRONT, default 16, SHALL set the horizontal front porch in pixels.
REQ-004 Parameter H_SYNC, default 96, SHALL set the horizontal sync width in pixels.
REQ-005 Parameter H_BACK, default 48, SHALL set the horizontal back porch in pixels, and SHALL be at least 1.
REQ-006 Parameter V_ACTIVE, default 480, SHALL set the visible lines per frame.
REQ-007 Parameter V_FRONT, default 10, SHALL set the vertical front porch in lines.
REQ-008 Parameter V_SYNC, default 2, SHALL set the vertical sync width in lines.
REQ-009 Parameter V_BACK, default 33, SHALL set the vertical back porch in lines, and SHALL be at least 1.
REQ-010 Parameter H_POL, default 0, SHALL set the horizontal sync active level (0 = active-low, 1 = active-high).
REQ-011 Parameter V_POL, default 0, SHALL set the vertical sync active level with the same encoding as H_POL.
REQ-012 Derived constants SHALL be H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK, V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK, HW = clog2(H_TOTAL) and VW = clog2(V_TOTAL).
REQ-013 Port `clock`: input, 1 bit; the system clock.
REQ-014 Port `res`: input, 1 bit; synchronous reset, active-low.
REQ-015 Port `pix_en`: input, 1 bit; pixel-tick enable.
REQ-016 Port `hsync`: output, 1 bit; horizontal sync.
REQ-017 Port `vsync`: output, 1 bit; vertical sync.
REQ-018 Port `video_on`: output, 1 bit; high inside the visible area.
REQ-019 Port `x`: output, HW bits; current horizontal count.
REQ-020 Port `y`: output, VW bits; current vertical count.
REQ-021 Port `line_start`: output, 1 bit; one-clock pulse at the start of each line.
REQ-022 Port `frame_start`: output, 1 bit; one-clock pulse at the start of each frame.

Function
REQ-023 The horizontal counter h SHALL advance by 1 on each clock edge where `pix_en` is 1, and SHALL hold its value when `pix_en` is 0.
REQ-024 When h = H_TOTAL-1 and `pix_en` is 1, h SHALL wrap to 0 and the vertical counter v SHALL advance by 1 on that same edge.
REQ-025 When v = V_TOTAL-1 and h wraps, v SHALL wrap to 0 on that same edge.
REQ-026 `x` SHALL equal h and `y` SHALL equal v at all times.
REQ-027 All outputs SHALL be registered and updated on the same edge as the counters, computed from the next counter values, so that every output is consistent with `x` and `y` with zero skew.
REQ-028 `hsync` SHALL be at level H_POL while H_ACTIVE+H_FRONT <= h <= H_ACTIVE+H_FRONT+H_SYNC-1, and at the inverse of H_POL otherwise.
REQ-029 `vsync` SHALL be at level V_POL while V_ACTIVE+V_FRONT <= v <= V_ACTIVE+V_FRONT+V_SYNC-1, and at the inverse of V_POL otherwise; `vsync` therefore changes only on edges where h wraps.
REQ-030 `video_on` SHALL be 1 exactly when h < H_ACTIVE and v < V_ACTIVE.
REQ-031 `line_start` SHALL be 1 for exactly one clock after an enabled edge that sets h to 0, and SHALL be 0 otherwise, including while `pix_en` stays low.
REQ-032 `frame_start` SHALL be 1 for exactly one clock after an enabled edge that sets h to 0 and v to 0.
REQ-033 When `frame_start` is 1, `line_start` SHALL also be 1.
REQ-034 Counter comparisons SHALL be done at HW or VW width, with no overflow beyond H_TOTAL-1 or V_TOTAL-1.

Reset
REQ-035 On any edge where `res` is 0, the block SHALL load h = H_TOTAL-1 and v = V_TOTAL-1, regardless of `pix_en`.
REQ-036 During reset, `hsync` SHALL be the inverse of H_POL and `vsync` SHALL be the inverse of V_POL.
REQ-037 During reset, `video_on`, `line_start` and `frame_start` SHALL all be 0.
REQ-038 Reset asserted mid-frame SHALL abort the frame immediately, with no partial sync pulse held after the reset edge.
REQ-039 After `res` returns to 1, the first enabled edge SHALL produce h = 0, v = 0, `video_on` = 1 and a `frame_start` pulse.

Verification
REQ-040 Scenario: defaults, `pix_en` tied high, reset released -> first `frame_start` one clock after the first edge; `line_start` every 800 clocks; `frame_start` every 420000 clocks.
REQ-041 Scenario: defaults -> `hsync` low for h = 656..751 (96 clocks per line); `vsync` low for lines v = 490..491 (1600 clocks); `video_on` high 640 clocks per line on lines 0..479 only.
REQ-042 Scenario: `pix_en` high every 4th clock -> counters and outputs hold between ticks; `line_start` stays one clock wide; line period is 3200 clocks.
REQ-043 Scenario: H_POL = 1, V_POL = 1 -> sync windows unchanged but both syncs idle low and pulse high; reset values are 0.
REQ-044 Scenario: reset pulsed at h = 700, v = 491 (inside vsync) -> `vsync` inactive on the reset edge; restart at (0,0) with `frame_start` after release.
REQ-045 Scenario: small parameters (H = 4/1/2/1, V = 3/1/1/1) -> exhaustive compare of `x`, `y` and every output against a reference model over 3 frames, with random `pix_en`.
